aqp_esp_notify_tx: RTL and testbench

FPGA→ESP message transmitter: the return direction of the ESP SPI command link. Core logic queues framed byte messages; the block raises `esp_notify` while any complete message is pending. When the ESP issues the notify-read command, the block serves the message bytes on the SPI slave's transmit path. It sits beside the SPI command receiver and shares the same SPI slave instance (`msg_start`/`msg_end`/`rxdata`/`txdata`/`txdata_ack`).

---
 rtl/aqp_esp_notify_tx.sv | 183 ++++++++++++++++++
 tb/tb_aqp_esp_notify_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/aqp_esp_notify_tx.sv
// rtl/aqp_esp_notify_tx.sv - FPGA-to-ESP message queue served over the shared SPI slave
module aqp_esp_notify_tx #(
    parameter int         DEPTH_LOG2      = 6,
    parameter int         MSGS_LOG2       = 2,
    parameter logic [7:0] CMD_NOTIFY_READ = 8'hF8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    input  logic       tx_last,
    output logic       tx_full,
    output logic       tx_drop,
    input  logic       msg_start,
    input  logic       msg_end,
    input  logic [7:0] rxdata,
    input  logic       rxdata_valid,
    output logic [7:0] txdata,
    input  logic       txdata_ack,
    output logic       esp_notify
);
    localparam int Depth = 1 << DEPTH_LOG2;
    localparam int Msgs  = 1 << MSGS_LOG2;
    localparam int UW    = DEPTH_LOG2 + 1;
    localparam int CW    = MSGS_LOG2 + 1;

    typedef enum logic [2:0] {StIdle, StCmd, StLen, StData, StSkip} state_t;

    logic [7:0]            mem [Depth];
    logic [DEPTH_LOG2-1:0] fifo_base [Msgs];
    logic [7:0]            fifo_len [Msgs];

    logic [DEPTH_LOG2-1:0] wr_ptr, msg_base, rd_ptr;
    logic [UW-1:0]         used, used_next;
    logic [7:0]            open_cnt;
    logic                  bad;
    logic [MSGS_LOG2-1:0]  fifo_head, fifo_tail;
    logic [CW-1:0]         fifo_cnt, fifo_cnt_next;

    state_t     state;
    logic [1:0] ack_cnt;
    logic [7:0] len_lat, len_rem;
    logic       retired;

    logic                  fifo_full, fifo_empty;
    logic [7:0]            head_len;
    logic [DEPTH_LOG2-1:0] head_base;
    logic                  bad_now, wr_accept, commit, drop;
    logic                  cmd_hit, len_ack, pop;

    assign tx_full    = (used == UW'(Depth));
    assign fifo_full  = (fifo_cnt == CW'(Msgs));
    assign fifo_empty = (fifo_cnt == '0);
    assign head_len   = fifo_empty ? 8'h00 : fifo_len[fifo_head];
    assign head_base  = fifo_base[fifo_head];

    // Once a message goes bad, its remaining bytes are swallowed until tx_last
    assign bad_now   = bad || (tx_wr && (tx_full || open_cnt == 8'hFF)) ||
                       (tx_wr && tx_last && fifo_full);
    assign wr_accept = tx_wr && !bad_now;
    assign commit    = tx_wr && tx_last && !bad_now;
    assign drop      = tx_wr && tx_last && bad_now;

    // A command byte decodes before a coincident ack, so that ack acts as StLen
    assign cmd_hit = (state == StCmd) && rxdata_valid && (rxdata == CMD_NOTIFY_READ);
    assign len_ack = txdata_ack && (ack_cnt == 2'd1) && ((state == StLen) || cmd_hit);
    assign pop     = msg_end && retired;

    assign fifo_cnt_next = fifo_cnt + CW'(commit) - CW'(pop);
    assign used_next     = used + UW'(wr_accept)
                         - (drop ? UW'(open_cnt) : UW'(0))
                         - (pop  ? UW'(len_lat)  : UW'(0));

    always_comb begin
        txdata = head_len;
        if (state == StData)
            txdata = mem[rd_ptr];
        else if (retired)
            txdata = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr] <= tx_data;
        if (commit) begin
            fifo_base[fifo_tail] <= msg_base;
            fifo_len[fifo_tail]  <= open_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            msg_base   <= '0;
            used       <= '0;
            open_cnt   <= '0;
            bad        <= 1'b0;
            fifo_head  <= '0;
            fifo_tail  <= '0;
            fifo_cnt   <= '0;
            tx_drop    <= 1'b0;
            esp_notify <= 1'b0;
        end else begin
            tx_drop    <= drop;
            esp_notify <= (fifo_cnt_next != '0);
            used       <= used_next;
            fifo_cnt   <= fifo_cnt_next;
            if (pop)
                fifo_head <= fifo_head + 1'b1;
            if (commit)
                fifo_tail <= fifo_tail + 1'b1;
            if (tx_wr && tx_last) begin
                bad      <= 1'b0;
                open_cnt <= '0;
                if (drop) begin
                    wr_ptr <= msg_base;
                end else begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    msg_base <= wr_ptr + 1'b1;
                end
            end else if (tx_wr) begin
                if (wr_accept) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    open_cnt <= open_cnt + 8'd1;
                end else begin
                    bad <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= StIdle;
            ack_cnt <= '0;
            len_lat <= '0;
            len_rem <= '0;
            retired <= 1'b0;
            rd_ptr  <= '0;
        end else begin
            if (txdata_ack && ack_cnt != 2'd3)
                ack_cnt <= ack_cnt + 2'd1;
            // Retiring skips any bytes the ESP left unread
            if (msg_end) begin
                retired <= 1'b0;
                if (retired)
                    rd_ptr <= head_base + DEPTH_LOG2'(len_lat);
            end
            if (msg_start) begin
                state   <= StCmd;
                ack_cnt <= '0;
            end else if (msg_end) begin
                state <= StIdle;
            end else begin
                case (state)
                    StCmd: begin
                        if (rxdata_valid)
                            state <= cmd_hit ? StLen : StSkip;
                    end
                    StData: begin
                        if (txdata_ack) begin
                            rd_ptr  <= rd_ptr + 1'b1;
                            len_rem <= len_rem - 8'd1;
                            if (len_rem == 8'd1)
                                state <= StSkip;
                        end
                    end
                    default: ;
                endcase
                if (len_ack) begin
                    len_lat <= head_len;
                    len_rem <= head_len;
                    if (head_len != 8'h00) begin
                        state   <= StData;
                        retired <= 1'b1;
                    end else begin
                        state <= StSkip;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_aqp_esp_notify_tx.sv
// tb/tb_aqp_esp_notify_tx.sv - directed bench for aqp_esp_notify_tx
module tb_aqp_esp_notify_tx;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_wr = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_full;
    logic       tx_drop;
    logic       msg_start = 1'b0;
    logic       msg_end = 1'b0;
    logic [7:0] rxdata = '0;
    logic       rxdata_valid = 1'b0;
    logic [7:0] txdata;
    logic       txdata_ack = 1'b0;
    logic       esp_notify;

    int tests = 0;
    int fails = 0;

    aqp_esp_notify_tx dut (
        .clk(clk), .reset_n(reset_n),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_last(tx_last),
        .tx_full(tx_full), .tx_drop(tx_drop),
        .msg_start(msg_start), .msg_end(msg_end),
        .rxdata(rxdata), .rxdata_valid(rxdata_valid),
        .txdata(txdata), .txdata_ack(txdata_ack),
        .esp_notify(esp_notify)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic last);
        tx_data = d;
        tx_wr   = 1'b1;
        tx_last = last;
        tick();
        tx_wr   = 1'b0;
        tx_last = 1'b0;
    endtask

    // exp holds n bytes, first byte in the most significant used position
    task automatic spi_read(input string tag, input logic [7:0] cmd, input int n,
                            input logic [63:0] exp);
        msg_start = 1'b1;
        tick();
        msg_start = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s byte%0d", tag, i), txdata, exp[8*(n-1-i) +: 8]);
            txdata_ack = 1'b1;
            tick();
            txdata_ack = 1'b0;
            if (i == 0) begin
                rxdata       = cmd;
                rxdata_valid = 1'b1;
                tick();
                rxdata_valid = 1'b0;
            end
            tick();
        end
        msg_end = 1'b1;
        tick();
        msg_end = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        check("rst txdata", txdata, 8'h00);
        check("rst tx_full", tx_full, 1'b0);
        check("rst tx_drop", tx_drop, 1'b0);
        check("rst notify", esp_notify, 1'b0);
        reset_n = 1'b1;
        tick();

        wr_byte(8'h11, 1'b0);
        wr_byte(8'h22, 1'b0);
        check("notify open msg", esp_notify, 1'b0);
        wr_byte(8'h33, 1'b1);
        check("notify commit", esp_notify, 1'b1);
        spi_read("basic", 8'hF8, 6, 64'h0303_1122_3300);
        check("notify after read", esp_notify, 1'b0);

        spi_read("empty", 8'hF8, 3, 64'h00_0000);

        wr_byte(8'h44, 1'b1);
        spi_read("badcmd", 8'h23, 3, 64'h01_0101);
        check("notify badcmd", esp_notify, 1'b1);
        spi_read("drain44", 8'hF8, 4, 64'h0101_4400);
        check("notify drain44", esp_notify, 1'b0);

        wr_byte(8'hAA, 1'b1);
        wr_byte(8'hBB, 1'b0);
        wr_byte(8'hCC, 1'b1);
        spi_read("short", 8'hF8, 2, 64'h0101);
        check("notify after short", esp_notify, 1'b1);
        spi_read("second", 8'hF8, 5, 64'h0202_BBCC_00);
        check("notify two done", esp_notify, 1'b0);

        // wr_ptr is now 7: fill all 64 entries, then overflow with tx_last
        for (int i = 0; i < 64; i++)
            wr_byte(8'(i), 1'b0);
        check("full", tx_full, 1'b1);
        wr_byte(8'hEE, 1'b1);
        check("drop pulse", tx_drop, 1'b1);
        check("full after drop", tx_full, 1'b0);
        check("notify after drop", esp_notify, 1'b0);
        tick();
        check("drop one cycle", tx_drop, 1'b0);

        // 56-byte filler at 7..62 read short, leaving both pointers at 63
        for (int i = 0; i < 55; i++)
            wr_byte(8'h10, 1'b0);
        wr_byte(8'h10, 1'b1);
        check("filler no drop", tx_drop, 1'b0);
        spi_read("filler", 8'hF8, 3, 64'h38_3810);
        wr_byte(8'h5A, 1'b0);
        wr_byte(8'hA5, 1'b1);
        spi_read("wrap", 8'hF8, 5, 64'h0202_5AA5_00);

        for (int k = 1; k <= 4; k++) begin
            wr_byte(8'(k), 1'b1);
            check($sformatf("msg%0d kept", k), tx_drop, 1'b0);
        end
        wr_byte(8'h05, 1'b1);
        check("msg5 dropped", tx_drop, 1'b1);
        spi_read("q1", 8'hF8, 4, 64'h0101_0100);
        spi_read("q2", 8'hF8, 4, 64'h0101_0200);
        spi_read("q3", 8'hF8, 4, 64'h0101_0300);
        check("notify q3", esp_notify, 1'b1);
        spi_read("q4", 8'hF8, 4, 64'h0101_0400);
        check("notify q4", esp_notify, 1'b0);
        spi_read("q5 empty", 8'hF8, 2, 64'h0000);

        wr_byte(8'h77, 1'b0);
        wr_byte(8'h88, 1'b0);
        wr_byte(8'h99, 1'b1);
        msg_start = 1'b1;
        tick();
        msg_start = 1'b0;
        check("rst rd byte0", txdata, 8'h03);
        txdata_ack = 1'b1;
        tick();
        txdata_ack   = 1'b0;
        rxdata       = 8'hF8;
        rxdata_valid = 1'b1;
        tick();
        rxdata_valid = 1'b0;
        check("rst rd byte1", txdata, 8'h03);
        txdata_ack = 1'b1;
        tick();
        txdata_ack = 1'b0;
        check("rst rd byte2", txdata, 8'h77);
        #2 reset_n = 1'b0;
        #1;
        check("midrst txdata", txdata, 8'h00);
        check("midrst notify", esp_notify, 1'b0);
        check("midrst tx_full", tx_full, 1'b0);
        tick();
        reset_n = 1'b1;
        msg_end = 1'b1;
        tick();
        msg_end = 1'b0;
        tick();
        spi_read("post rst", 8'hF8, 2, 64'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
